// File: rtl/branch_resolve.sv
// Branch resolution unit: holds the branch in EX, evaluates its condition
// against the EX operands, strobes the predictor update, raises a one-cycle
// flush with the corrected PC on a mispredict and keeps branch statistics.
module branch_resolve (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_insBRA,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_imm,
  input  logic [2:0]  id_funct3,
  input  logic        id_pred_taken,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic        stall,
  output logic        update_en,
  output logic        actual_taken,
  output logic [31:0] update_pc,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  typedef enum logic {RUN, SQUASH} state_t;

  state_t      state;
  state_t      next_state;

  logic        ex_valid;
  logic        ex_resolved;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [2:0]  ex_funct3;
  logic        ex_pred;

  logic        cond_ok;
  logic        taken;
  logic        resolve;
  logic        mispredict;
  logic [31:0] target;

  // Evaluate the branch condition held in EX; 010/011 are not branches.
  always_comb begin
    cond_ok = 1'b1;
    taken   = 1'b0;
    case (ex_funct3)
      3'b000:  taken = (ex_rs1 == ex_rs2);
      3'b001:  taken = (ex_rs1 != ex_rs2);
      3'b100:  taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  taken = (ex_rs1 <  ex_rs2);
      3'b111:  taken = (ex_rs1 >= ex_rs2);
      default: cond_ok = 1'b0;
    endcase
  end

  // A valid EX entry resolves once; the resolved flag blocks repeats while stalled.
  always_comb begin
    resolve    = (state == RUN) && ex_valid && !ex_resolved && cond_ok;
    mispredict = resolve && (taken != ex_pred);
    target     = taken ? (ex_pc + ex_imm) : (ex_pc + 32'd4);
  end

  // Next-state logic: a mispredict costs exactly one squash cycle.
  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (mispredict) next_state = SQUASH;
      SQUASH:  next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  // EX register: drop wrong-path work on mispredict/squash, otherwise follow stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_resolved <= 1'b0;
      ex_pc       <= 32'd0;
      ex_imm      <= 32'd0;
      ex_funct3   <= 3'd0;
      ex_pred     <= 1'b0;
    end else if (mispredict || (state == SQUASH)) begin
      ex_valid    <= 1'b0;
      ex_resolved <= 1'b0;
    end else if (!stall) begin
      ex_valid    <= id_valid && id_insBRA;
      ex_resolved <= 1'b0;
      ex_pc       <= id_pc;
      ex_imm      <= id_imm;
      ex_funct3   <= id_funct3;
      ex_pred     <= id_pred_taken;
    end else if (resolve) begin
      ex_resolved <= 1'b1;
    end
  end

  // Registered resolution outputs and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      update_en    <= 1'b0;
      actual_taken <= 1'b0;
      update_pc    <= 32'd0;
      flush        <= 1'b0;
      redirect_pc  <= 32'd0;
      branch_cnt   <= 32'd0;
      mispred_cnt  <= 32'd0;
    end else begin
      update_en    <= resolve;
      actual_taken <= resolve && taken;
      flush        <= mispredict;
      redirect_pc  <= mispredict ? target : 32'd0;
      if (resolve)    update_pc   <= ex_pc;
      if (resolve)    branch_cnt  <= branch_cnt + 32'd1;
      if (mispredict) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule
